// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end.
//   XLEN_DEFAULT      default data/address width
//   RESET_PC_DEFAULT  default first fetch address after reset
//   INST_NOP          canonical RV32I nop (addi x0, x0, 0)
//   opcode_e          major opcodes of the I/S/B instruction formats
package if_prefetch_queue_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int          PC_STEP          = 4;

    typedef enum logic [6:0] {
        OPC_ITYPE = 7'b0010011,
        OPC_STYPE = 7'b0100011,
        OPC_BTYPE = 7'b1100011
    } opcode_e;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Synchronous FIFO with extra-MSB pointers. Used for both the per-request
// pc tags and the {inst, pc} queue in front of decode.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush; wins over push and pop
//   push, wdata  write side; a push while full is accepted only with a pop
//   pop, rdata   read side; rdata is the current head (undefined when empty)
//   full, empty  status flags
//   count        current occupancy, 0..DEPTH
module inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // The head slot is only overwritten at the clock edge, so a push into a
    // full FIFO is safe when the head is being popped in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem
// requests under a credit limit, buffers returned words and presents
// {inst, pc} to decode. A redirect flushes the queue and arranges for
// the responses of already-issued requests to be discarded.
//   imem_req_*   request channel (valid/ready), word-aligned address
//   imem_resp_*  response channel, in order, no backpressure
//   redirect_*   flush and restart fetch at redirect_pc (low bits ignored)
//   id_*         head of queue toward decode (valid/ready)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// valid never depends on ready; once raised, imem_req_valid/addr and
// id_valid/inst/pc hold until the transfer, except that a redirect
// withdraws both (decode flushes together with this block).
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [XLEN-1:0]   id_pc
);

    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam int            QW         = INST_W + XLEN;
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

    // Holds off requests for the first cycle after reset release.
    logic             en_q, en_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

    logic             req_fire;
    logic             resp_keep;
    logic             id_fire;
    logic [CW:0]      in_flight;

    logic [XLEN-1:0]  tag_pc;
    logic             tag_full, tag_empty;
    logic [CW-1:0]    tag_count;

    logic [QW-1:0]    q_rdata;
    logic             q_full, q_empty;
    logic [CW-1:0]    q_count;

    // Every issued request holds a queue slot until its word is consumed,
    // so the queue can never overflow.
    always_comb begin
        in_flight      = {1'b0, q_count} + {1'b0, outstanding_q};
        imem_req_valid = en_q && !redirect_valid && (in_flight < CREDIT_MAX);
    end

    assign imem_req_addr = fetch_pc_q;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign resp_keep     = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign id_valid      = !q_empty;
    assign id_fire       = id_valid && id_ready && !redirect_valid;
    assign id_inst       = q_empty ? 32'h0 : q_rdata[QW-1:XLEN];
    assign id_pc         = q_empty ? '0 : q_rdata[XLEN-1:0];

    always_comb begin
        en_d          = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        drop_cnt_d    = drop_cnt_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            // Everything still outstanding after this cycle predates the
            // redirect; those responses are the next ones to arrive.
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            en_q          <= en_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Address of each issued request, consumed by its response (kept or
    // dropped), so it is never flushed by a redirect.
    inst_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .push  (req_fire),
        .wdata (fetch_pc_q),
        .pop   (imem_resp_valid),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    inst_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_inst_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (resp_keep),
        .wdata ({imem_resp_data, tag_pc}),
        .pop   (id_fire),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    a_credit: assert property (@(posedge clk) disable iff (!rst_n) in_flight <= CREDIT_MAX);
    a_drop:   assert property (@(posedge clk) disable iff (!rst_n) drop_cnt_q <= outstanding_q);
    a_tags:   assert property (@(posedge clk) disable iff (!rst_n) tag_count == outstanding_q);
    a_resp:   assert property (@(posedge clk) disable iff (!rst_n) imem_resp_valid |-> !tag_empty);
    a_issue:  assert property (@(posedge clk) disable iff (!rst_n) req_fire |-> !tag_full);
    a_push:   assert property (@(posedge clk) disable iff (!rst_n) resp_keep |-> (!q_full || id_fire));

endmodule
